// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and the store byte-enable helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes touched by an access of size funct3 at byte offset lo.
    // Misaligned halfwords snap to {lo[1],0}; words always cover all lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension. Purely combinational so the
// core's writeback path can reuse it on raw memory words.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[8*addr_lo +: 8];
    assign lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    // Extend the selected lane according to the access type.
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0, lane_h};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, waits
// WAIT_CYCLES, performs the access on an internal word array and returns
// the result on a valid/ready response channel.
// Optional: define DMEM_MISALIGN_ERR_EN to flag misaligned H/W accesses
// as illegal instead of silently ignoring the low address bits.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rd_data,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            r_read, r_write;
    logic [2:0]      r_f3;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;

    logic [31:0]     mem [DEPTH];

    logic            a_read, a_write;
    logic [2:0]      a_f3;
    logic [AW+1:0]   a_addr;
    logic [31:0]     a_wdata;
    logic            exec, legal;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic [31:0]     wlanes, ld_data;
    logic            unused_addr_hi;

    // Address bits above the array wrap and are deliberately dropped.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // With zero wait states the access runs on the accept edge, so the
    // live request feeds the datapath while idle; otherwise the latched copy.
    assign a_read  = (state == IDLE) ? mem_read       : r_read;
    assign a_write = (state == IDLE) ? mem_write      : r_write;
    assign a_f3    = (state == IDLE) ? funct3         : r_f3;
    assign a_addr  = (state == IDLE) ? addr[AW+1:0]   : r_addr;
    assign a_wdata = (state == IDLE) ? wr_data        : r_wdata;

    assign exec = (WAIT_CYCLES == 0) ? (state == IDLE && req_valid)
                                     : (state == WAIT && cnt == '0);

    assign idx = a_addr[AW+1:2];
    assign be  = byte_en(a_f3, a_addr[1:0]);

    // Decide whether the request may touch the array.
    always_comb begin
        legal = a_read ^ a_write;
        case (a_f3)
            F3_B, F3_H, F3_W: ;
            F3_BU, F3_HU:     if (!a_read) legal = 1'b0;
            default:          legal = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_ERR_EN
        if (a_f3[1:0] == 2'b01 && a_addr[0])         legal = 1'b0;
        if (a_f3 == F3_W && a_addr[1:0] != 2'b00)    legal = 1'b0;
`endif
    end

    // Replicate store data so every enabled lane sees its right-aligned source.
    always_comb begin
        wlanes = a_wdata;
        case (a_f3[1:0])
            2'b00:   wlanes = {4{a_wdata[7:0]}};
            2'b01:   wlanes = {2{a_wdata[15:0]}};
            default: wlanes = a_wdata;
        endcase
    end

    dmem_load_ext u_ext (
        .word    (mem[idx]),
        .funct3  (a_f3),
        .addr_lo (a_addr[1:0]),
        .data    (ld_data)
    );

    // Byte-lane store commit; rst_n gates it so reset never lets a store land.
    always_ff @(posedge clk) begin
        if (rst_n && exec && legal && a_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // Request FSM: latch on accept, count wait states, hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            rd_data <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_read  <= mem_read;
                    r_write <= mem_write;
                    r_f3    <= funct3;
                    r_addr  <= addr[AW+1:0];
                    r_wdata <= wr_data;
                    if (WAIT_CYCLES == 0) begin
                        state <= RESP;
                    end else begin
                        cnt   <= CW'(WAIT_CYCLES - 1);
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == '0) state <= RESP;
                      else           cnt   <= cnt - 1'b1;
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (exec) begin
                rd_data <= (legal && a_read) ? ld_data : '0;
                rsp_err <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, WAIT_CYCLES=2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wr_data, rd_data;
    logic        rsp_valid, rsp_ready, rsp_err;

    int tests = 0;
    int fails = 0;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rd_data(rd_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // One full request/response; lat counts falling edges after the accept edge
    // until rsp_valid is seen (-1 on timeout).
    task automatic txn(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e, output int lat);
        int n;
        @(negedge clk);
        mem_read = mr; mem_write = mw; funct3 = f3; addr = a; wr_data = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        d = rd_data; e = rsp_err;
        if (!rsp_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b0; addr = '0; wr_data = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] d; logic e; int lat;
        txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL sw_latency got %0d want 3", lat); end
        tests++; if ({e, d} !== 33'h0) begin fails++; $display("FAIL sw_rsp got err=%b d=%h want err=0 d=0", e, d); end
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL lw_latency got %0d want 3", lat); end
        tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL lw_10 got err=%b d=%h want err=0 d=deadbeef", e, d); end
    endtask

    task automatic test_byte_half;
        logic [31:0] d; logic e; int lat;
        txn(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, d, e, lat);
        txn(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, d, e, lat);
        tests++; if (d !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_13 got %h want ffffff80", d); end
        txn(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, d, e, lat);
        tests++; if (d !== 32'h00000080) begin fails++; $display("FAIL lbu_13 got %h want 00000080", d); end
        // Word is now 0x80ADBEEF, upper half 0x80AD.
        txn(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, d, e, lat);
        tests++; if (d !== 32'hFFFF80AD) begin fails++; $display("FAIL lh_12 got %h want ffff80ad", d); end
        txn(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, d, e, lat);
        tests++; if (d !== 32'h0000BEEF) begin fails++; $display("FAIL lhu_10 got %h want 0000beef", d); end
        txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat);
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Second request presented while the first is in flight.
        funct3 = 3'b100; addr = 32'h13;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b d=%h want v=1 rdy=0 d=deadbeef", i, rsp_valid, req_ready, rd_data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        tests++; if (n !== 3 || rd_data !== 32'h000000DE) begin
            fails++; $display("FAIL bp_second got lat=%0d d=%h want lat=3 d=000000de", n, rd_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        logic [31:0] d; logic e; int lat;
        txn(1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, d, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'h0 || lat !== 3) begin fails++; $display("FAIL ill_rw got err=%b d=%h lat=%0d want 1 0 3", e, d, lat); end
        txn(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL ill_none got err=%b d=%h want 1 0", e, d); end
        txn(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, d, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL ill_f3 got err=%b d=%h want 1 0", e, d); end
        txn(1'b0, 1'b1, 3'b100, 32'h10, 32'h22222222, d, e, lat);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL ill_sbu got err=%b want 1", e); end
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
        tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL ill_nowrite got %h want deadbeef", d); end
        txn(1'b1, 1'b0, 3'b010, 32'h410, 32'h0, d, e, lat);
        tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL wrap got %h want deadbeef", d); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] d; logic e; int lat;
        txn(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, d, e, lat);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20;
        wr_data = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_state got rdy=%b v=%b want 1 0", req_ready, rsp_valid); end
        @(negedge clk); rst_n = 1'b1;
        txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat);
        tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL midrst_keep got %h want cafef00d", d); end
    endtask

    task automatic test_half_and_misalign;
        logic [31:0] d; logic e; int lat;
        txn(1'b0, 1'b1, 3'b001, 32'h22, 32'h00007FFF, d, e, lat);
        txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat);
        tests++; if (d !== 32'h7FFFF00D) begin fails++; $display("FAIL sh_22 got %h want 7ffff00d", d); end
        txn(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, d, e, lat);
        tests++; if (d !== 32'h00007FFF) begin fails++; $display("FAIL lh_22 got %h want 00007fff", d); end
`ifdef DMEM_MISALIGN_ERR_EN
        txn(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, d, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL mis_lw got err=%b d=%h want 1 0", e, d); end
        txn(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, d, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL mis_lh got err=%b d=%h want 1 0", e, d); end
`else
        txn(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, d, e, lat);
        tests++; if (e !== 1'b0 || d !== 32'h7FFFF00D) begin fails++; $display("FAIL mis_lw got err=%b d=%h want 0 7ffff00d", e, d); end
        txn(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, d, e, lat);
        tests++; if (e !== 1'b0 || d !== 32'hFFFFF00D) begin fails++; $display("FAIL mis_lh got err=%b d=%h want 0 fffff00d", e, d); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_backpressure();
        test_illegal();
        test_reset_mid_wait();
        test_half_and_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
